// File: rtl/dlx_run_monitor.sv
// Run monitor for the DLX CPU bench: counts RUN cycles and retired instructions, and stops on halt, retire stall or cycle budget.
// Optional macro DLX_RUN_MONITOR_FINISH_EN: print the run summary and end simulation on entry to DONE.
module dlx_run_monitor #(
    parameter int CYCLE_WIDTH = 32,
    parameter int MAX_CYCLES  = 1000,
    parameter int STALL_LIMIT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   retire,
    input  logic                   halt,
    output logic                   running,
    output logic                   done,
    output logic [1:0]             cause,
    output logic [CYCLE_WIDTH-1:0] cycle_count,
    output logic [CYCLE_WIDTH-1:0] retire_count,
    output logic [15:0]            stall_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_HALT   = 2'b01;
    localparam logic [1:0] CAUSE_STALL  = 2'b10;
    localparam logic [1:0] CAUSE_BUDGET = 2'b11;

    localparam logic [CYCLE_WIDTH-1:0] LAST_CYCLE = CYCLE_WIDTH'(MAX_CYCLES - 1);
    localparam logic [15:0]            LAST_STALL = 16'(STALL_LIMIT - 1);
    localparam logic [CYCLE_WIDTH-1:0] CNT_ONE    = CYCLE_WIDTH'(1);

    state_t                   state, state_n;
    logic [1:0]               cause_n;
    logic [CYCLE_WIDTH-1:0]   cycle_n, retire_n;
    logic [15:0]              stall_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cause        <= CAUSE_NONE;
            cycle_count  <= '0;
            retire_count <= '0;
            stall_count  <= '0;
        end else begin
            state        <= state_n;
            cause        <= cause_n;
            cycle_count  <= cycle_n;
            retire_count <= retire_n;
            stall_count  <= stall_n;
        end
    end

    always_comb begin
        state_n  = state;
        cause_n  = cause;
        cycle_n  = cycle_count;
        retire_n = retire_count;
        stall_n  = stall_count;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n  = ST_RUN;
                    cause_n  = CAUSE_NONE;
                    cycle_n  = '0;
                    retire_n = '0;
                    stall_n  = '0;
                end
            end
            ST_RUN: begin
                // Counters saturate at all-ones rather than wrapping.
                if (cycle_count != '1)
                    cycle_n = cycle_count + CNT_ONE;
                if (retire) begin
                    stall_n = '0;
                    if (retire_count != '1)
                        retire_n = retire_count + CNT_ONE;
                end else if (stall_count != 16'hFFFF) begin
                    stall_n = stall_count + 16'd1;
                end
                // Exit decisions look at pre-edge counts, halt first.
                if (halt) begin
                    state_n = ST_DONE;
                    cause_n = CAUSE_HALT;
                end else if (!retire && stall_count == LAST_STALL) begin
                    state_n = ST_DONE;
                    cause_n = CAUSE_STALL;
                end else if (cycle_count == LAST_CYCLE) begin
                    state_n = ST_DONE;
                    cause_n = CAUSE_BUDGET;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign running = (state == ST_RUN);
    assign done    = (state == ST_DONE);

`ifdef DLX_RUN_MONITOR_FINISH_EN
    always @(posedge clk) begin
        if (!reset && state == ST_RUN && state_n == ST_DONE) begin
            $display("dlx_run_monitor: run ended cause=%0d cycles=%0d retired=%0d",
                     cause_n, cycle_n, retire_n);
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_dlx_run_monitor.sv
// Directed bench for dlx_run_monitor: reset, halt, stall, budget, priority, restart and saturation scenarios.
module tb_dlx_run_monitor;

    logic        clk = 1'b0;
    logic        reset, start, retire, halt;

    logic        running, done;
    logic [1:0]  cause;
    logic [31:0] cycle_count, retire_count;
    logic [15:0] stall_count;

    logic        s_running, s_done;
    logic [1:0]  s_cause;
    logic [3:0]  s_cycle_count, s_retire_count;
    logic [15:0] s_stall_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dlx_run_monitor #(.CYCLE_WIDTH(32), .MAX_CYCLES(20), .STALL_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .retire(retire), .halt(halt),
        .running(running), .done(done), .cause(cause),
        .cycle_count(cycle_count), .retire_count(retire_count), .stall_count(stall_count)
    );

    dlx_run_monitor #(.CYCLE_WIDTH(4), .MAX_CYCLES(15), .STALL_LIMIT(64)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .retire(retire), .halt(halt),
        .running(s_running), .done(s_done), .cause(s_cause),
        .cycle_count(s_cycle_count), .retire_count(s_retire_count), .stall_count(s_stall_count)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; retire = 1'b0; halt = 1'b0;
        tick(2);
        checks++;
        if ({running, done, cause, cycle_count, retire_count, stall_count} !== '0) begin
            errors++;
            $display("FAIL reset_state: got run=%b done=%b cause=%0d cyc=%0d ret=%0d stl=%0d want all 0",
                     running, done, cause, cycle_count, retire_count, stall_count);
        end
        reset = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        checks++;
        if (running !== 1'b1 || cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL start_enter_run: got run=%b cyc=%0d want run=1 cyc=0", running, cycle_count);
        end
        retire = 1'b1; tick(5);
        checks++;
        if (cycle_count !== 32'd5 || retire_count !== 32'd5) begin
            errors++;
            $display("FAIL run_5_cycles: got cyc=%0d ret=%0d want 5/5", cycle_count, retire_count);
        end
        reset = 1'b1; tick(1); reset = 1'b0;
        checks++;
        if ({running, done, cause, cycle_count, retire_count, stall_count} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got run=%b done=%b cyc=%0d ret=%0d want all 0",
                     running, done, cycle_count, retire_count);
        end
        tick(3);
        checks++;
        if (running !== 1'b0 || retire_count !== 32'd0 || cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL retire_in_idle: got run=%b ret=%0d cyc=%0d want 0/0/0",
                     running, retire_count, cycle_count);
        end
        retire = 1'b0;
    endtask

    task automatic test_halt;
        start = 1'b1; tick(1); start = 1'b0;
        retire = 1'b1; tick(10);
        halt = 1'b1; tick(1);
        halt = 1'b0; retire = 1'b0;
        checks++;
        if (done !== 1'b1 || running !== 1'b0 || cause !== 2'b01 ||
            cycle_count !== 32'd11 || retire_count !== 32'd11) begin
            errors++;
            $display("FAIL halt_exit: got done=%b run=%b cause=%0d cyc=%0d ret=%0d want 1/0/1/11/11",
                     done, running, cause, cycle_count, retire_count);
        end
        retire = 1'b1; halt = 1'b1; tick(2); retire = 1'b0; halt = 1'b0;
        checks++;
        if (done !== 1'b1 || cause !== 2'b01 || cycle_count !== 32'd11 || retire_count !== 32'd11) begin
            errors++;
            $display("FAIL done_frozen: got done=%b cause=%0d cyc=%0d ret=%0d want 1/1/11/11",
                     done, cause, cycle_count, retire_count);
        end
    endtask

    task automatic test_stall;
        start = 1'b1; tick(1); start = 1'b0;
        checks++;
        if (running !== 1'b1 || done !== 1'b0 || cause !== 2'b00 ||
            cycle_count !== 32'd0 || retire_count !== 32'd0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL restart_from_done: got run=%b done=%b cause=%0d cyc=%0d ret=%0d want 1/0/0/0/0",
                     running, done, cause, cycle_count, retire_count);
        end
        retire = 1'b1; tick(3); retire = 1'b0;
        tick(3);
        checks++;
        if (running !== 1'b1 || stall_count !== 16'd3) begin
            errors++;
            $display("FAIL stall_pre_exit: got run=%b stl=%0d want 1/3", running, stall_count);
        end
        tick(1);
        checks++;
        if (done !== 1'b1 || cause !== 2'b10 || stall_count !== 16'd4 ||
            retire_count !== 32'd3 || cycle_count !== 32'd7) begin
            errors++;
            $display("FAIL stall_exit: got done=%b cause=%0d stl=%0d ret=%0d cyc=%0d want 1/2/4/3/7",
                     done, cause, stall_count, retire_count, cycle_count);
        end
    endtask

    task automatic test_budget;
        start = 1'b1; tick(1); start = 1'b0;
        retire = 1'b1; tick(9);
        start = 1'b1; tick(1); start = 1'b0;
        checks++;
        if (running !== 1'b1 || cycle_count !== 32'd10 || retire_count !== 32'd10) begin
            errors++;
            $display("FAIL start_ignored_in_run: got run=%b cyc=%0d ret=%0d want 1/10/10",
                     running, cycle_count, retire_count);
        end
        tick(9);
        checks++;
        if (running !== 1'b1 || cycle_count !== 32'd19) begin
            errors++;
            $display("FAIL budget_pre_exit: got run=%b cyc=%0d want 1/19", running, cycle_count);
        end
        tick(1); retire = 1'b0;
        checks++;
        if (done !== 1'b1 || cause !== 2'b11 || cycle_count !== 32'd20 || retire_count !== 32'd20) begin
            errors++;
            $display("FAIL budget_exit: got done=%b cause=%0d cyc=%0d ret=%0d want 1/3/20/20",
                     done, cause, cycle_count, retire_count);
        end
    endtask

    task automatic test_priority;
        start = 1'b1; tick(1); start = 1'b0;
        tick(3);
        halt = 1'b1; tick(1); halt = 1'b0;
        checks++;
        if (done !== 1'b1 || cause !== 2'b01 || stall_count !== 16'd4 || cycle_count !== 32'd4) begin
            errors++;
            $display("FAIL halt_over_stall: got done=%b cause=%0d stl=%0d cyc=%0d want 1/1/4/4",
                     done, cause, stall_count, cycle_count);
        end
    endtask

    task automatic test_saturation;
        reset = 1'b1; tick(1); reset = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        retire = 1'b1; tick(15);
        checks++;
        if (s_done !== 1'b1 || s_cause !== 2'b11 || s_cycle_count !== 4'd15 || s_retire_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_exit: got done=%b cause=%0d cyc=%0d ret=%0d want 1/3/15/15",
                     s_done, s_cause, s_cycle_count, s_retire_count);
        end
        tick(3); retire = 1'b0;
        checks++;
        if (s_retire_count !== 4'd15 || s_cycle_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold: got cyc=%0d ret=%0d want 15/15", s_cycle_count, s_retire_count);
        end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_stall();
        test_budget();
        test_priority();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
